// File: rtl/adder_4bits_pkg.sv
// Shared width, nibble type and reset values for the 4-bit ripple-carry adder.
package adder_4bits_pkg;
  localparam int ADDER_WIDTH = 4;

  typedef logic [ADDER_WIDTH-1:0] nibble_t;

  localparam nibble_t S_RST = '0;
  localparam logic    C_RST = 1'b0;
endpackage

// File: rtl/adder_4bits_full_adder.sv
// Single-bit full adder: purely combinational, no state, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/adder_4bits.sv
// 4-bit ripple-carry adder; latency 1 cycle (REGISTER_OUTPUT=1) or 0, one sum per clock, no backpressure.
// Define ADDER_4BITS_OVF_EN to add the signed-overflow output ovf_o.
module adder_4bits
  import adder_4bits_pkg::*;
#(
  parameter int REGISTER_OUTPUT = 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  nibble_t a_i,
  input  nibble_t b_i,
  input  logic    valid_i,
  output nibble_t s_o,
  output logic    c_o,
  output logic    valid_o
`ifdef ADDER_4BITS_OVF_EN
  ,
  output logic    ovf_o
`endif
);

  logic [ADDER_WIDTH:0] carry;
  nibble_t              sum;

  assign carry[0] = 1'b0;

  for (genvar k = 0; k < ADDER_WIDTH; k++) begin : g_stage
    full_adder u_fa (
      .a  (a_i[k]),
      .b  (b_i[k]),
      .ci (carry[k]),
      .s  (sum[k]),
      .co (carry[k+1])
    );
  end

`ifdef ADDER_4BITS_OVF_EN
  // Two's-complement overflow: like-signed operands produce a result of the other sign.
  logic ovf;
  assign ovf = (a_i[ADDER_WIDTH-1] == b_i[ADDER_WIDTH-1]) &&
               (sum[ADDER_WIDTH-1] != a_i[ADDER_WIDTH-1]);
`endif

  if (REGISTER_OUTPUT != 0) begin : g_reg
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s_o     <= S_RST;
        c_o     <= C_RST;
        valid_o <= 1'b0;
      end else begin
        valid_o <= valid_i;
        if (valid_i) begin
          s_o <= sum;
          c_o <= carry[ADDER_WIDTH];
        end
      end
    end

`ifdef ADDER_4BITS_OVF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ovf_o <= 1'b0;
      end else if (valid_i) begin
        ovf_o <= ovf;
      end
    end
`endif
  end else begin : g_comb
    // Reset only masks valid_o here; the data path stays transparent.
    assign s_o     = sum;
    assign c_o     = carry[ADDER_WIDTH];
    assign valid_o = valid_i & ~rst_i;
`ifdef ADDER_4BITS_OVF_EN
    assign ovf_o   = ovf;
`endif
  end

endmodule

// File: tb/tb_adder_4bits.sv
// Bench for adder_4bits (registered build): arithmetic reference model checked every cycle plus literal expectations.
module tb_adder_4bits;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       valid = 1'b0;
  logic [3:0] s_o;
  logic       c_o;
  logic       valid_o;
`ifdef ADDER_4BITS_OVF_EN
  logic       ovf_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: last accepted operands summed as plain integers.
  int   m_sum = 0;
  logic m_v   = 1'b0;
  logic m_ovf = 1'b0;

  always #5 clk = ~clk;

  adder_4bits #(.REGISTER_OUTPUT(1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a),
    .b_i     (b),
    .valid_i (valid),
    .s_o     (s_o),
    .c_o     (c_o),
    .valid_o (valid_o)
`ifdef ADDER_4BITS_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum = 0;
      m_v   = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_v = valid;
      if (valid) begin
        int sa, sb, ss;
        m_sum = int'(a) + int'(b);
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        ss = sa + sb;
        m_ovf = (ss > 7) || (ss < -8);
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({c_o, s_o} !== 5'(m_sum) || valid_o !== m_v) begin
      errors++;
      $display("FAIL model t=%0t: got c=%0b s=%h v=%0b, need sum=%h v=%0b",
               $time, c_o, s_o, valid_o, m_sum, m_v);
    end
`ifdef ADDER_4BITS_OVF_EN
    checks++;
    if (ovf_o !== m_ovf) begin
      errors++;
      $display("FAIL model_ovf t=%0t: got %0b, need %0b", $time, ovf_o, m_ovf);
    end
`endif
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int es, input int ec, input int ev);
    chk({name, ".s"}, int'(s_o), es);
    chk({name, ".c"}, int'(c_o), ec);
    chk({name, ".v"}, int'(valid_o), ev);
  endtask

  // Called at posedge+1; operands are captured on the next edge, outputs checked just after it.
  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tv);
    a = ta;
    b = tb;
    valid = tv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk_out("reset", 0, 0, 0);
    a = 4'h3;
    b = 4'h3;
    valid = 1'b1;
    @(posedge clk);
    #1;
    chk_out("reset_discard", 0, 0, 0);
    rst = 1'b0;
    apply(4'h0, 4'h0, 1'b0);
    chk_out("post_reset_idle", 0, 0, 0);

    apply(4'hF, 4'h1, 1'b1);
    chk_out("carry", 0, 1, 1);
`ifdef ADDER_4BITS_OVF_EN
    chk("carry.ovf", int'(ovf_o), 0);
`endif
    apply(4'hF, 4'hF, 1'b1);
    chk_out("max", 4'hE, 1, 1);
    apply(4'h0, 4'h0, 1'b1);
    chk_out("zero", 0, 0, 1);
    apply(4'h5, 4'h3, 1'b1);
    chk_out("five_three", 4'h8, 0, 1);
    apply(4'hF, 4'hF, 1'b0);
    chk_out("hold", 4'h8, 0, 0);
    apply(4'h7, 4'h1, 1'b1);
    chk_out("pos_ovf", 4'h8, 0, 1);
`ifdef ADDER_4BITS_OVF_EN
    chk("pos_ovf.ovf", int'(ovf_o), 1);
`endif
    apply(4'h8, 4'h8, 1'b1);
    chk_out("neg_ovf", 0, 1, 1);
`ifdef ADDER_4BITS_OVF_EN
    chk("neg_ovf.ovf", int'(ovf_o), 1);
`endif
    apply(4'h4, 4'h5, 1'b1);
    chk_out("nine", 4'h9, 0, 1);

    // Asynchronous reset mid-cycle, well before the next edge.
    valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_reset", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        apply(4'(i), 4'(j), 1'b1);
      end
    end
    chk_out("exhaustive_last", 4'hE, 1, 1);
    apply(4'h0, 4'h0, 1'b0);
    chk_out("final_hold", 4'hE, 1, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
